// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared sequential ALU: arbitrates, clears the ALU,
// runs one operation, captures its result, and keeps a per-requester carry flag.
module alu_scheduler #(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid0,
  input  logic       req_valid1,
  output logic       req_ready0,
  output logic       req_ready1,
  input  logic [7:0] req_op0,
  input  logic [7:0] req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_b1,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic [15:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_sign,
  output logic       carry_flag0,
  output logic       carry_flag1,
  output logic       alu_rst,
  output logic       alu_enable,
  output logic [7:0] alu_operation,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_cpu_carry,
  input  logic [7:0] alu_result_l,
  input  logic [7:0] alu_result_h,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign
);

  typedef enum logic [1:0] {IDLE, CLR, EXEC, CAPT} state_t;

  state_t     state, state_next;
  logic [7:0] op_q, a_q, b_q;
  logic       id_q;
  logic       last_grant;
  logic       grant_id;
  logic       accept;
  logic       carry_op;

  // On a tie, round-robin favours whoever did not win last time.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid0 && req_valid1) begin
      grant_id = FAIR ? ~last_grant : 1'b0;
    end else if (req_valid1) begin
      grant_id = 1'b1;
    end
    accept     = (state == IDLE) && !rst && (req_valid0 || req_valid1);
    req_ready0 = accept && !grant_id;
    req_ready1 = accept && grant_id;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = CLR;
      CLR:  state_next = EXEC;
      EXEC: state_next = CAPT;
      CAPT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ALU drive is zero outside EXEC so the ALU sees clean inputs when idle.
  always_comb begin
    alu_rst       = rst || (state == CLR);
    alu_enable    = 1'b0;
    alu_operation = 8'h00;
    alu_op1       = 8'h00;
    alu_op2       = 8'h00;
    alu_cpu_carry = 1'b0;
    if (state == EXEC) begin
      alu_enable    = 1'b1;
      alu_operation = op_q;
      alu_op1       = a_q;
      alu_op2       = b_q;
      alu_cpu_carry = id_q ? carry_flag1 : carry_flag0;
    end
  end

  // Only ops that architecturally define carry may update the requester's flag.
  always_comb begin
    carry_op = 1'b0;
    case (op_q)
      8'h88, 8'h89, 8'h8A, 8'h8B,
      8'h02, 8'h04, 8'h05, 8'h08, 8'h09: carry_op = 1'b1;
      default:                           carry_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      op_q        <= 8'h00;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      id_q        <= 1'b0;
      rsp_valid0  <= 1'b0;
      rsp_valid1  <= 1'b0;
      rsp_result  <= 16'h0000;
      rsp_carry   <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_sign    <= 1'b0;
      carry_flag0 <= 1'b0;
      carry_flag1 <= 1'b0;
    end else begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      if (accept) begin
        op_q       <= grant_id ? req_op1 : req_op0;
        a_q        <= grant_id ? req_a1  : req_a0;
        b_q        <= grant_id ? req_b1  : req_b0;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == CAPT) begin
        rsp_result <= {alu_result_h, alu_result_l};
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        rsp_sign   <= alu_sign;
        if (id_q) rsp_valid1 <= 1'b1;
        else      rsp_valid0 <= 1'b1;
        if (carry_op) begin
          if (id_q) carry_flag1 <= alu_carry;
          else      carry_flag0 <= alu_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: a small ALU model sits behind the round-robin
// instance, and a fixed-priority instance shares its request inputs.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid0, req_valid1;
  logic [7:0]  req_op0, req_op1, req_a0, req_a1, req_b0, req_b1;
  logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_sign, carry_flag0, carry_flag1;
  logic        alu_rst, alu_enable, alu_cpu_carry;
  logic [7:0]  alu_operation, alu_op1, alu_op2;
  logic [7:0]  alu_result_l, alu_result_h;
  logic        alu_carry, alu_zero, alu_sign;

  logic        f_ready0, f_ready1, f_rsp_valid0, f_rsp_valid1;
  logic [15:0] f_rsp_result;
  logic        f_rsp_carry, f_rsp_zero, f_rsp_sign, f_carry_flag0, f_carry_flag1;
  logic        f_alu_rst, f_alu_enable, f_alu_cpu_carry;
  logic [7:0]  f_alu_operation, f_alu_op1, f_alu_op2;

  int   total = 0;
  int   bad   = 0;
  logic model_cf0, model_cf1;

  always #5 clk = ~clk;

  alu_scheduler #(.FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
    .carry_flag0(carry_flag0), .carry_flag1(carry_flag1),
    .alu_rst(alu_rst), .alu_enable(alu_enable), .alu_operation(alu_operation),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cpu_carry(alu_cpu_carry),
    .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign)
  );

  alu_scheduler #(.FAIR(1'b0)) dut_fixed (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(f_ready0), .req_ready1(f_ready1),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid0(f_rsp_valid0), .rsp_valid1(f_rsp_valid1),
    .rsp_result(f_rsp_result), .rsp_carry(f_rsp_carry), .rsp_zero(f_rsp_zero), .rsp_sign(f_rsp_sign),
    .carry_flag0(f_carry_flag0), .carry_flag1(f_carry_flag1),
    .alu_rst(f_alu_rst), .alu_enable(f_alu_enable), .alu_operation(f_alu_operation),
    .alu_op1(f_alu_op1), .alu_op2(f_alu_op2), .alu_cpu_carry(f_alu_cpu_carry),
    .alu_result_l(8'h00), .alu_result_h(8'h00),
    .alu_carry(1'b0), .alu_zero(1'b0), .alu_sign(1'b0)
  );

  // Returns {result_h, result_l, carry, zero, sign}; SUB reports magnitude plus sign.
  function automatic logic [18:0] alu_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic        c, s;
    r = 16'h0000;
    c = 1'b0;
    s = 1'b0;
    case (op)
      8'h88, 8'h89, 8'h8A, 8'h8B: {c, r[7:0]} = {1'b0, a} + {1'b0, b};
      8'h8C: begin
        if (a >= b) r[7:0] = a - b;
        else begin
          r[7:0] = b - a;
          s = 1'b1;
        end
      end
      8'h90:   r = {8'h00, a} * {8'h00, b};
      8'h94:   r[7:0] = a & b;
      8'h04:   c = 1'b1;
      8'h05:   c = 1'b0;
      default: r[7:0] = a;
    endcase
    if (op != 8'h8C) s = r[7];
    return {r, c, (r == 16'h0000), s};
  endfunction

  always @(posedge clk) begin
    if (alu_rst) {alu_result_h, alu_result_l, alu_carry, alu_zero, alu_sign} <= '0;
    else if (alu_enable)
      {alu_result_h, alu_result_l, alu_carry, alu_zero, alu_sign} <= alu_model(alu_operation, alu_op1, alu_op2);
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one request and follows it through CLR, EXEC, CAPT to the response cycle.
  task automatic apply_stimulus(input logic id, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] exp_res, input logic exp_c, input logic exp_z,
                                input logic exp_s, input logic exp_cf0, input logic exp_cf1);
    int waited;
    waited = 0;
    if (id) begin
      req_valid1 = 1'b1; req_op1 = op; req_a1 = a; req_b1 = b;
    end else begin
      req_valid0 = 1'b1; req_op0 = op; req_a0 = a; req_b0 = b;
    end
    #1;
    while (!(id ? req_ready1 : req_ready0) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check_output("accept", {31'd0, id ? req_ready1 : req_ready0}, 32'd1);
    @(negedge clk);
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    #1;
    check_output("clr_alu_rst", {31'd0, alu_rst}, 32'd1);
    check_output("clr_idle_drive", {req_ready1, req_ready0, alu_enable, alu_operation, alu_op1, alu_op2}, 32'd0);
    @(negedge clk); #1;
    check_output("exec_enable", {31'd0, alu_enable}, 32'd1);
    check_output("exec_op", {24'd0, alu_operation}, {24'd0, op});
    check_output("exec_operands", {16'd0, alu_op1, alu_op2}, {16'd0, a, b});
    check_output("exec_cpu_carry", {31'd0, alu_cpu_carry}, {31'd0, id ? model_cf1 : model_cf0});
    @(negedge clk); #1;
    check_output("capt_no_rsp", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    @(negedge clk); #1;
    check_output("rsp_valid", {30'd0, rsp_valid1, rsp_valid0}, id ? 32'd2 : 32'd1);
    check_output("rsp_result", {16'd0, rsp_result}, {16'd0, exp_res});
    check_output("rsp_flags", {29'd0, rsp_carry, rsp_zero, rsp_sign}, {29'd0, exp_c, exp_z, exp_s});
    check_output("carry_flags", {30'd0, carry_flag1, carry_flag0}, {30'd0, exp_cf1, exp_cf0});
    model_cf0 = exp_cf0;
    model_cf1 = exp_cf1;
  endtask

  initial begin
    logic [3:0] exp_main, exp_fixed;
    rst = 1'b1;
    req_valid0 = 1'b1; req_valid1 = 1'b0;
    req_op0 = 8'h00; req_op1 = 8'h00;
    req_a0 = 8'h00; req_a1 = 8'h00; req_b0 = 8'h00; req_b1 = 8'h00;
    model_cf0 = 1'b0;
    model_cf1 = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_output("reset_ready", {30'd0, req_ready1, req_ready0}, 32'd0);
    check_output("reset_alu_rst", {31'd0, alu_rst}, 32'd1);
    check_output("reset_rsp", {rsp_valid1, rsp_valid0, rsp_carry, rsp_zero, rsp_sign, rsp_result},
                 32'd0);
    check_output("reset_carry", {30'd0, carry_flag1, carry_flag0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid0 = 1'b0;
    @(negedge clk);

    apply_stimulus(1'b0, 8'h88, 8'hF0, 8'h20, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    check_output("hold_no_pulse", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    check_output("hold_result", {16'd0, rsp_result}, 32'h0010);
    apply_stimulus(1'b0, 8'h94, 8'h0F, 8'hF0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h90, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h8C, 8'h03, 8'h05, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h04, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 8'hFF, 8'h5A, 8'h00, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 8'h05, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Abort an ADD in EXEC; nothing may complete and both flags clear.
    req_valid0 = 1'b1; req_op0 = 8'h88; req_a0 = 8'hF0; req_b0 = 8'h20;
    #1;
    check_output("abort_accept", {31'd0, req_ready0}, 32'd1);
    @(negedge clk);
    req_valid0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("abort_alu_rst", {31'd0, alu_rst}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("abort_carry", {30'd0, carry_flag1, carry_flag0}, 32'd0);
    check_output("abort_rsp_data", {16'd0, rsp_result}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_output("abort_no_rsp", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
      @(negedge clk); #1;
    end
    model_cf0 = 1'b0;
    model_cf1 = 1'b0;
    apply_stimulus(1'b0, 8'h88, 8'hF0, 8'h20, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Both requesters held valid from reset: alternate on one instance, 0 always on the other.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid0 = 1'b1; req_op0 = 8'h94; req_a0 = 8'h33; req_b0 = 8'h0F;
    req_valid1 = 1'b1; req_op1 = 8'h88; req_a1 = 8'h01; req_b1 = 8'h02;
    for (int c = 0; c < 13; c++) begin
      #1;
      exp_main  = 4'b0000;
      exp_fixed = 4'b0000;
      if (c % 4 == 0) begin
        exp_main[1:0]  = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
        exp_fixed[1:0] = 2'b01;
        if (c > 0) begin
          exp_main[3:2]  = ((c / 4) % 2 == 1) ? 2'b01 : 2'b10;
          exp_fixed[3:2] = 2'b01;
        end
      end
      check_output("fair_grant", {28'd0, rsp_valid1, rsp_valid0, req_ready1, req_ready0}, {28'd0, exp_main});
      check_output("fixed_grant", {28'd0, f_rsp_valid1, f_rsp_valid0, f_ready1, f_ready0}, {28'd0, exp_fixed});
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
